// File: rtl/mempool_tile_noc_arbiter.sv
// Round-robin arbiter sharing one NoC request link between tile master ports, with response routing
// and per-port outstanding limits. Define MEMPOOL_NOC_ARB_PERF_EN to build the grant/stall counters.
module mempool_tile_noc_arbiter #(
    parameter int unsigned NumPorts       = 3,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RspWidth       = 32,
    localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumPorts-1:0][ReqWidth-1:0]  req_i,
    input  logic [NumPorts-1:0]                req_valid_i,
    output logic [NumPorts-1:0]                req_ready_o,
    output logic [ReqWidth-1:0]                req_o,
    output logic [PortW-1:0]                   req_port_o,
    output logic                               req_valid_o,
    input  logic                               req_ready_i,
    input  logic [RspWidth-1:0]                rsp_i,
    input  logic [PortW-1:0]                   rsp_port_i,
    input  logic                               rsp_valid_i,
    output logic                               rsp_ready_o,
    output logic [NumPorts-1:0][RspWidth-1:0]  rsp_o,
    output logic [NumPorts-1:0]                rsp_valid_o,
    input  logic [NumPorts-1:0]                rsp_ready_i,
    output logic                               idle_o,
    output logic                               err_o,
    output logic [31:0]                        perf_grants_o,
    output logic [31:0]                        perf_stalls_o
);

    // state | meaning
    // ARB   | pick first eligible port at or after rr_q, combinational grant
    // LOCK  | granted request stalled by the NoC, hold lock_q until handshake
    localparam logic [0:0] StArb  = 1'b0;
    localparam logic [0:0] StLock = 1'b1;

    logic [0:0]                      state_q, state_d;
    logic [PortW-1:0]                rr_q, rr_d;
    logic [PortW-1:0]                lock_q, lock_d;
    logic [NumPorts-1:0][CntW-1:0]   cnt_q, cnt_d;
    logic                            err_q, err_d;

    logic [NumPorts-1:0]             eligible;
    logic                            arb_found;
    logic [PortW-1:0]                arb_idx;
    logic                            grant_valid;
    logic [PortW-1:0]                grant_idx;
    logic                            req_hs;
    logic                            rsp_in_range;
    logic                            rsp_hs;
    logic [NumPorts-1:0]             cnt_inc;
    logic [NumPorts-1:0]             cnt_dec;

    always_comb begin
        eligible = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            eligible[p] = req_valid_i[p] && (cnt_q[p] < CntW'(MaxOutstanding));
        end
    end

    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = 0;
        for (int k = 0; k < int'(NumPorts); k++) begin
            idx = int'(rr_q) + k;
            if (idx >= int'(NumPorts)) begin
                idx = idx - int'(NumPorts);
            end
            if (!arb_found && eligible[PortW'(idx)]) begin
                arb_found = 1'b1;
                arb_idx   = PortW'(idx);
            end
        end
    end

    // A locked request keeps its slot even if other ports become eligible meanwhile.
    always_comb begin
        grant_idx   = arb_idx;
        grant_valid = arb_found;
        if (state_q == StLock) begin
            grant_idx   = lock_q;
            grant_valid = req_valid_i[lock_q];
        end
    end

    assign req_valid_o = rst_ni & grant_valid;
    assign req_port_o  = grant_idx;
    assign req_o       = req_i[grant_idx];
    assign req_hs      = req_valid_o & req_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (rst_ni && grant_valid) begin
            req_ready_o[grant_idx] = req_ready_i;
        end
    end

    assign rsp_in_range = (int'(rsp_port_i) < int'(NumPorts));
    assign rsp_o        = {NumPorts{rsp_i}};

    // Out-of-range responses are sunk so the NoC link cannot wedge; they only raise err_o.
    always_comb begin
        rsp_valid_o = '0;
        rsp_ready_o = 1'b0;
        if (rst_ni) begin
            if (rsp_in_range) begin
                rsp_valid_o[rsp_port_i] = rsp_valid_i;
                rsp_ready_o             = rsp_ready_i[rsp_port_i];
            end else begin
                rsp_ready_o = 1'b1;
            end
        end
    end

    assign rsp_hs = rsp_valid_i & rsp_ready_o;

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        cnt_d   = cnt_q;
        err_d   = err_q;
        for (int p = 0; p < int'(NumPorts); p++) begin
            cnt_inc[p] = req_hs && (grant_idx == PortW'(p));
            cnt_dec[p] = rsp_hs && rsp_in_range && (rsp_port_i == PortW'(p)) && (cnt_q[p] != '0);
            if (cnt_inc[p] && !cnt_dec[p]) begin
                cnt_d[p] = cnt_q[p] + CntW'(1);
            end else if (cnt_dec[p] && !cnt_inc[p]) begin
                cnt_d[p] = cnt_q[p] - CntW'(1);
            end
        end
        if (rsp_hs) begin
            if (!rsp_in_range) begin
                err_d = 1'b1;
            end else if (cnt_q[rsp_port_i] == '0) begin
                err_d = 1'b1;
            end
        end
        if ((state_q == StLock) && !req_valid_i[lock_q]) begin
            err_d = 1'b1;
        end
    end

    // A port abandoning its locked request releases the link back to arbitration.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        if (req_hs) begin
            state_d = StArb;
            rr_d    = (grant_idx == PortW'(NumPorts - 1)) ? '0 : grant_idx + PortW'(1);
        end else if (grant_valid) begin
            state_d = StLock;
            lock_d  = grant_idx;
        end else begin
            state_d = StArb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StArb;
            rr_q    <= '0;
            lock_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign err_o  = err_q;
    assign idle_o = !rst_ni || ((cnt_q == '0) && (req_valid_i == '0) && (state_q == StArb));

`ifdef MEMPOOL_NOC_ARB_PERF_EN
    logic [31:0] perf_grants_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_grants_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (req_hs) begin
                perf_grants_q <= perf_grants_q + 32'd1;
            end
            if (req_valid_o && !req_ready_i) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_grants_o = perf_grants_q;
    assign perf_stalls_o = perf_stalls_q;
`else
    assign perf_grants_o = '0;
    assign perf_stalls_o = '0;
`endif

endmodule

// File: tb/tb_mempool_tile_noc_arbiter.sv
// Self-checking bench for mempool_tile_noc_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration, locking and outstanding counts.
module tb_mempool_tile_noc_arbiter;

    localparam int N    = 3;
    localparam int MAXO = 2;
    localparam int RW   = 64;
    localparam int SW   = 32;
    localparam int PW   = 2;
`ifdef MEMPOOL_NOC_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N-1:0][RW-1:0]    req_data;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready_w;
    logic [RW-1:0]           req_out_w;
    logic [PW-1:0]           req_port_w;
    logic                    req_valid_w;
    logic                    req_ready;
    logic [SW-1:0]           rsp_data;
    logic [PW-1:0]           rsp_port;
    logic                    rsp_valid;
    logic                    rsp_ready_w;
    logic [N-1:0][SW-1:0]    rsp_out_w;
    logic [N-1:0]            rsp_valid_w;
    logic [N-1:0]            rsp_ready;
    logic                    idle_w;
    logic                    err_w;
    logic [31:0]             perf_grants_w;
    logic [31:0]             perf_stalls_w;

    always #5 clk = ~clk;

    mempool_tile_noc_arbiter #(
        .NumPorts(N), .MaxOutstanding(MAXO), .ReqWidth(RW), .RspWidth(SW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready_w),
        .req_o(req_out_w), .req_port_o(req_port_w), .req_valid_o(req_valid_w), .req_ready_i(req_ready),
        .rsp_i(rsp_data), .rsp_port_i(rsp_port), .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready_w),
        .rsp_o(rsp_out_w), .rsp_valid_o(rsp_valid_w), .rsp_ready_i(rsp_ready),
        .idle_o(idle_w), .err_o(err_w),
        .perf_grants_o(perf_grants_w), .perf_stalls_o(perf_stalls_w)
    );

    int          checks = 0;
    int          errors = 0;
    int          m_cnt[N];
    int          m_rr;
    bit          m_locked;
    int          m_lock;
    bit          m_err;
    logic [31:0] m_pg;
    logic [31:0] m_ps;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int g;
        bit vo;
        bit hs;
        bit exp_rr;
        bit all_zero;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        if (!rst_n) begin
            for (int p = 0; p < N; p++) m_cnt[p] = 0;
            m_rr = 0; m_locked = 0; m_lock = 0; m_err = 0; m_pg = 0; m_ps = 0;
            chk("rst_req_valid_o", req_valid_w, 0);
            chk("rst_req_ready_o", req_ready_w, 0);
            chk("rst_rsp_valid_o", rsp_valid_w, 0);
            chk("rst_rsp_ready_o", rsp_ready_w, 0);
            chk("rst_idle_o", idle_w, 1);
            chk("rst_err_o", err_w, 0);
            chk("rst_perf_grants", perf_grants_w, 0);
            chk("rst_perf_stalls", perf_stalls_w, 0);
            return;
        end
        vo = 0;
        g  = 0;
        if (m_locked) begin
            g  = m_lock;
            vo = req_valid[g];
        end else begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_rr + k) % N;
                if (!vo && req_valid[p] && m_cnt[p] < MAXO) begin
                    vo = 1;
                    g  = p;
                end
            end
        end
        chk("req_valid_o", req_valid_w, vo);
        if (vo) begin
            chk("req_port_o", req_port_w, g);
            chk("req_o", req_out_w, req_data[g]);
        end
        exp_rdy = '0;
        if (vo) exp_rdy[g] = req_ready;
        chk("req_ready_o", req_ready_w, exp_rdy);

        exp_rv = '0;
        exp_rr = 1;
        if (rsp_port < N) begin
            exp_rv[rsp_port] = rsp_valid;
            exp_rr = rsp_ready[rsp_port];
        end
        chk("rsp_valid_o", rsp_valid_w, exp_rv);
        chk("rsp_ready_o", rsp_ready_w, exp_rr);
        for (int p = 0; p < N; p++) chk("rsp_o", rsp_out_w[p], rsp_data);

        all_zero = 1;
        for (int p = 0; p < N; p++) if (m_cnt[p] != 0) all_zero = 0;
        chk("idle_o", idle_w, all_zero && (req_valid == 0) && !m_locked);
        chk("err_o", err_w, m_err);
        chk("perf_grants_o", perf_grants_w, PERF ? m_pg : 32'd0);
        chk("perf_stalls_o", perf_stalls_w, PERF ? m_ps : 32'd0);

        hs = vo && req_ready;
        if (rsp_valid && exp_rr) begin
            if (rsp_port >= N) m_err = 1;
            else if (m_cnt[rsp_port] == 0) m_err = 1;
            else m_cnt[rsp_port]--;
        end
        if (hs) begin
            m_cnt[g]++;
            m_rr = (g + 1) % N;
            m_locked = 0;
            m_pg++;
        end else if (vo) begin
            m_locked = 1;
            m_lock = g;
        end else if (m_locked) begin
            m_locked = 0;
            m_err = 1;
        end
        if (vo && !req_ready) m_ps++;
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r);
        req_valid = v;
        req_ready = r;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_port = '0; rsp_ready = '0; rsp_data = '0;
        for (int p = 0; p < N; p++) req_data[p] = 64'(p + 1) * 64'h0101_0101_0101_0101;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        step(); adv(); step(); adv();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        adv();
        do_reset();

        // round robin over three always-valid ports
        drive(3'b111, 1'b1);
        step(); chk("rr_grant_a", req_port_w, 0); adv();
        step(); chk("rr_grant_b", req_port_w, 1); adv();
        step(); chk("rr_grant_c", req_port_w, 2); adv();
        step(); chk("rr_grant_d", req_port_w, 0); adv();

        // lock on port 1 while port 0 keeps requesting
        do_reset();
        drive(3'b001, 1'b1);
        step(); adv();
        drive(3'b011, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lock_port", req_port_w, 1);
            chk("lock_data", req_out_w, 64'h0202_0202_0202_0202);
            adv();
            req_data[0] = {$urandom, $urandom};
        end
        req_ready = 1'b1;
        step();
        chk("lock_hs_port", req_port_w, 1);
        chk("lock_stalls", perf_stalls_w, PERF ? 32'd4 : 32'd0);
        adv();
        drive(3'b111, 1'b1);
        step(); chk("after_lock_port", req_port_w, 2); adv();

        // outstanding limit on port 0
        do_reset();
        drive(3'b001, 1'b1);
        step(); adv(); step(); adv();
        step(); chk("limit_blocked", req_valid_w, 0); adv();
        rsp_valid = 1'b1; rsp_port = 2'd0; rsp_ready = 3'b001;
        step();
        chk("limit_rsp_route", rsp_valid_w, 3'b001);
        chk("limit_still_blocked", req_valid_w, 0);
        adv();
        rsp_valid = 1'b0;
        step();
        chk("limit_reenabled", req_valid_w, 1);
        chk("limit_reenabled_port", req_port_w, 0);
        adv();

        // simultaneous request and response on port 2
        do_reset();
        drive(3'b100, 1'b1);
        step(); adv();
        rsp_valid = 1'b1; rsp_port = 2'd2; rsp_ready = 3'b100;
        step();
        chk("simul_req_ready", req_ready_w, 3'b100);
        chk("simul_rsp_ready", rsp_ready_w, 1);
        adv();
        rsp_valid = 1'b0; drive(3'b000, 1'b0);
        step(); chk("simul_not_idle", idle_w, 0); adv();
        rsp_valid = 1'b1;
        step(); adv();
        rsp_valid = 1'b0;
        step(); chk("simul_idle_after", idle_w, 1); adv();

        // error on response to an empty port, cleared by reset
        do_reset();
        rsp_valid = 1'b1; rsp_port = 2'd1; rsp_ready = 3'b010;
        step(); chk("err_before", err_w, 0); adv();
        rsp_valid = 1'b0;
        step(); chk("err_set", err_w, 1); adv();
        step(); chk("err_held", err_w, 1); adv();
        rst_n = 1'b0;
        #1;
        chk("err_async_clear", err_w, 0);
        step(); adv();
        rst_n = 1'b1;

        // async reset in the middle of a lock
        do_reset();
        drive(3'b010, 1'b0);
        step(); chk("midlock_grant", req_port_w, 1); adv();
        drive(3'b111, 1'b0);
        step(); chk("midlock_held", req_port_w, 1); adv();
        rst_n = 1'b0;
        #1;
        chk("midlock_rst_valid", req_valid_w, 0);
        chk("midlock_rst_idle", idle_w, 1);
        step(); adv();
        rst_n = 1'b1;
        drive(3'b111, 1'b1);
        step(); chk("midlock_rr_zero", req_port_w, 0); adv();

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 700 == 699) do_reset();
            for (int p = 0; p < N; p++) req_data[p] = {$urandom, $urandom};
            req_valid = N'($urandom_range(0, 7));
            if (m_locked && $urandom_range(0, 199) != 0) req_valid[m_lock] = 1'b1;
            req_ready = ($urandom_range(0, 2) != 0);
            rsp_data  = $urandom;
            rsp_port  = ($urandom_range(0, 49) == 0) ? 2'd3 : PW'($urandom_range(0, N - 1));
            if (rsp_port < N && m_cnt[rsp_port] > 0) rsp_valid = $urandom_range(0, 1) == 1;
            else rsp_valid = ($urandom_range(0, 99) == 0);
            rsp_ready = N'($urandom_range(0, 7));
            step();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mempool_tile_noc_arbiter.md
MEMPOOL_TILE_NOC_ARBITER -- requirements
Module: mempool_tile_noc_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 3, number of TCDM remote master ports sharing one NoC request link (>=2).
REQ-002 SHALL have parameter MaxOutstanding, default 8, per-port limit on requests awaiting a response (>=1).
REQ-003 SHALL have parameter ReqWidth, default 64, request payload bits.
REQ-004 SHALL have parameter RspWidth, default 32, response payload bits; PortW = clog2(NumPorts), CntW = clog2(MaxOutstanding+1).
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port req_i, input, NumPorts x ReqWidth, per-port request payload.
REQ-008 SHALL have ports req_valid_i (input) and req_ready_o (output), NumPorts each, per-port request handshake.
REQ-009 SHALL have ports req_o (output, ReqWidth), req_port_o (output, PortW), req_valid_o (output, 1) and req_ready_i (input, 1), the shared NoC request link.
REQ-010 SHALL have ports rsp_i (input, RspWidth), rsp_port_i (input, PortW), rsp_valid_i (input, 1) and rsp_ready_o (output, 1), the NoC response link.
REQ-011 SHALL have ports rsp_o (output, NumPorts x RspWidth), rsp_valid_o (output, NumPorts) and rsp_ready_i (input, NumPorts), per-port responses.
REQ-012 SHALL have ports idle_o (output, 1), no outstanding or pending traffic, and err_o (output, 1), sticky protocol error.
REQ-013 SHALL have ports perf_grants_o and perf_stalls_o, output, 32 each, performance counters.

Function
REQ-014 SHALL treat port p as eligible when req_valid_i[p]=1 and outstanding count cnt[p] < MaxOutstanding.
REQ-015 SHALL operate two states. ARB: grant the first eligible port at or after rr_q, with wrap-around. LOCK: hold the registered grant.
REQ-016 SHALL, in ARB, present the winner on req_o/req_port_o/req_valid_o in the same cycle (0-cycle latency); req_valid_o=0 if no port is eligible.
REQ-017 SHALL enter LOCK when req_valid_o=1 and req_ready_i=0; in LOCK the output SHALL stay on the locked port, payload passed through, regardless of eligibility of other ports, until handshake.
REQ-018 SHALL drive req_ready_o[g]=req_ready_i for the granted port g only; all other bits SHALL be 0.
REQ-019 SHALL, on request handshake of port g, set rr_q to (g+1) mod NumPorts, return to ARB, and increment cnt[g].
REQ-020 SHALL route the response combinationally: rsp_valid_o[rsp_port_i]=rsp_valid_i, rsp_o[p]=rsp_i for all p, rsp_ready_o=rsp_ready_i[rsp_port_i].
REQ-021 SHALL decrement cnt[p] on response handshake for port p; simultaneous increment and decrement on the same port SHALL leave cnt unchanged.
REQ-022 SHALL set err_o on a response handshake to a port with cnt=0, or with rsp_port_i >= NumPorts; the counter SHALL NOT underflow, and the response SHALL still be routed when in range.
REQ-023 SHALL drive idle_o=1 when all cnt=0, no req_valid_i is set and the state is ARB.
REQ-024 SHALL NOT allow a port that drops req_valid_i in LOCK; this is a protocol violation that sets err_o.

Reset
REQ-025 SHALL on rst_ni=0 asynchronously set: state ARB, rr_q=0, all cnt=0, err_o=0, perf counters=0, req_valid_o=0, req_ready_o=0, rsp_valid_o=0, rsp_ready_o=0, idle_o=1.
REQ-026 SHALL, on reset mid-transaction, discard the lock and all counts; late responses after reset SHALL set err_o.

Configuration
REQ-027 SHALL compile in the performance counters only when MEMPOOL_NOC_ARB_PERF_EN is defined.
REQ-028 SHALL, with MEMPOOL_NOC_ARB_PERF_EN defined, have perf_grants_o count request handshakes and perf_stalls_o count cycles with req_valid_o=1 and req_ready_i=0. Both counters SHALL wrap at 2^32.
REQ-029 SHALL, without MEMPOOL_NOC_ARB_PERF_EN, tie perf_grants_o and perf_stalls_o to 0 with no counter flops.

Verification
REQ-030 SHALL cover round-robin: all 3 ports valid, req_ready_i=1 -> grants 0,1,2,0 on consecutive cycles.
REQ-031 SHALL cover lock: port 1 granted with req_ready_i=0 for 4 cycles while port 0 is valid -> req_port_o=1 stable, req_o stable, perf_stalls_o=4; handshake in cycle 5, then port 2 is granted next.
REQ-032 SHALL cover the limit: MaxOutstanding=2, port 0 sends 2 requests with no responses -> port 0 is ineligible and req_valid_o=0; a response to port 0 re-enables it on the next cycle.
REQ-033 SHALL cover simultaneous events: request and response handshakes on port 2 in the same cycle with cnt[2]=1 -> cnt[2] stays 1 and idle_o=0.
REQ-034 SHALL cover errors: a response with rsp_port_i=1 while cnt[1]=0 -> err_o=1 next cycle and held; rst_ni pulse clears it to 0.
REQ-035 SHALL cover async reset asserted mid-LOCK -> req_valid_o=0 immediately, idle_o=1, rr_q=0.
